tone_generator: RTL and testbench
=================================

# tone_generator

Converts the 4-bit note code from the song sequencer into an audible square wave for the board's piezo/speaker pin. It sits directly downstream of the auto-play and keyboard note sources and produces the single output pin.

- Each valid note selects a fixed half-period divisor.
- A down-counter toggles the output at every half-period.
- Pitch changes and silences take effect only at half-period boundaries, so no truncated high pulse ever reaches the speaker.

## Interface
Parameters:
- CNT_W, 18, width of the half-period counter; must hold 191110.
- SIM_SHIFT, 0, right-shift applied to every table half-period for simulation; legal range 0..15.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- note  in  4  note code from the sequencer; may change on any cycle.
- mute  in  1  forces silence when 1; same effect as a silent code.
- speaker  out  1  square-wave output, registered.
- playing  out  1  1 while the FSM is in TONE, registered.

Note codes and half-periods (table value = round(100e6/(2f))):
- 0: none, silent.
- 1: C4, 191110.
- 2: D, 170265.
- 3: E, 151685.
- 4: F, 143172.
- 5: G, 127551.
- 6: A, 113636.
- 7: B, 101239.
- 8: C5, 95557.
- 9..15: silent.
- Effective half-period HP = table value >> SIM_SHIFT.

## Operation
- Input stage: note_q <= note every cycle. "Silent" means note_q is 0, note_q is 9..15, or mute = 1; mute is sampled directly, not registered.
- FSM has two states, IDLE and TONE.
- IDLE:
  - speaker = 0, playing = 0.
  - If not silent: cnt <= HP(note_q) - 1, speaker <= 1, go to TONE.
- TONE, when cnt != 0: cnt <= cnt - 1, speaker holds.
- TONE, speaker = 1 and cnt == 0:
  - speaker <= 0.
  - If silent: go to IDLE.
  - Else: cnt <= HP(note_q) - 1.
- TONE, speaker = 0:
  - If silent on any cycle: go to IDLE immediately, cnt <= 0. Aborting a low phase is glitch-free.
  - Else, when cnt == 0: speaker <= 1, cnt <= HP(note_q) - 1.
- Pitch change: the new HP is latched only at the next reload. The half-period in progress always completes at the old pitch.
- Same note repeated across sequencer steps: the waveform continues without phase reset.
- A none step between repeats silences as described above.
- No arithmetic wrap: cnt only decrements from HP-1 ≥ 1 down to 0.

## Timing
- Reset values: speaker 0, playing 0, note_q 0, cnt 0, state IDLE.
- RESET wins over all other conditions in the same cycle, including mid-tone; speaker drops to 0 at that edge.
- Start latency: note becomes valid at edge k (sampled into note_q). At edge k+1, speaker = 1 and playing = 1.
- Each half-period lasts exactly HP cycles, so the full period is 2·HP cycles.
- Silence latency:
  - Speaker low: 2 edges after the note goes silent, playing = 0.
  - Speaker high: speaker falls at the end of the current high phase, and playing = 0 on that same edge.
- mute acts one cycle faster than a note code, because it is not registered.
- A note change and a reload on the same edge: the reload uses the old note_q. The new code is seen one cycle later, at the next reload.

## Test plan
- Setup for all scenarios: SIM_SHIFT = 10.
- Reset, then hold note = 5 (G, HP = 124) -> speaker rises 1 cycle after note_q = 5. High 124 cycles, low 124 cycles, repeating. playing = 1 throughout.
- Steady G, then switch to note = 6 (A, HP = 110) mid-high-phase -> the current high phase still lasts 124 cycles. The following phases are 110 cycles each, with no short pulse.
- Steady E (HP = 148), then note = 0 during a high phase -> high completes at 148 cycles, speaker stays 0 afterwards, playing falls on that edge. Repeat with the switch during a low phase -> playing = 0 two edges after the switch.
- note = 12 from reset -> speaker and playing stay 0 for 1000 cycles. Then note = 1 (C4, HP = 186) -> 186/186-cycle square wave.
- Assert mute for 1 cycle during a low phase of D (HP = 166) -> FSM goes to IDLE. With note still 2, the tone restarts 1 cycle later with a full 166-cycle high phase.
- Assert RESET mid-high-phase of C5 (HP = 93) -> speaker = 0 and playing = 0 at the next edge. After release with note = 8, the tone restarts per the start latency.

Source files
------------

// File: rtl/tone_generator.sv
// tone_generator
//
// Turns the 4-bit note code from the song sequencer into a square wave for the
// piezo/speaker pin. Each valid code selects a fixed half-period. A down-counter
// toggles the output once per half-period. Pitch changes and silences are only
// honoured at half-period boundaries, so a truncated high pulse never reaches the
// speaker. The one exception is a low phase: aborting it cannot glitch the pin,
// so silence takes effect there immediately.
//
// Parameters:
//   CNT_W     width of the half-period counter (must hold 191110)
//   SIM_SHIFT right-shift applied to every table half-period (0..15), for simulation
//
// Ports:
//   CLK      in   system clock, 100 MHz
//   RESET    in   synchronous, active-high reset
//   note     in   [3:0] note code (0 and 9..15 are silent); may change on any cycle
//   mute     in   forces silence; used unregistered, so it acts one cycle before a code
//   speaker  out  registered square-wave output
//   playing  out  registered, 1 while the FSM is in TONE

module tone_generator #(
    parameter int CNT_W     = 18,
    parameter int SIM_SHIFT = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] note,
    input  logic       mute,
    output logic       speaker,
    output logic       playing
);

    typedef enum logic {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       note_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             speaker_nxt;
    logic             playing_nxt;
    logic             silent;
    logic [CNT_W-1:0] reload;

    // Half-period in clock cycles, round(100e6 / (2 f)), scaled down by SIM_SHIFT.
    // Silent codes return 0; that value is never loaded because silence blocks
    // every reload.
    function automatic logic [CNT_W-1:0] half_period(input logic [3:0] code);
        logic [31:0] full;
        case (code)
            4'd1:    full = 32'd191110;  // C4
            4'd2:    full = 32'd170265;  // D
            4'd3:    full = 32'd151685;  // E
            4'd4:    full = 32'd143172;  // F
            4'd5:    full = 32'd127551;  // G
            4'd6:    full = 32'd113636;  // A
            4'd7:    full = 32'd101239;  // B
            4'd8:    full = 32'd95557;   // C5
            default: full = 32'd0;
        endcase
        full = full >> SIM_SHIFT;
        return full[CNT_W-1:0];
    endfunction

    // mute is deliberately not registered; the note code is.
    assign silent = mute || (note_q == 4'd0) || (note_q > 4'd8);

    // The counter is loaded with HP-1 so that each phase spans exactly HP cycles,
    // including the cycle on which the toggle happens.
    assign reload = half_period(note_q) - CNT_ONE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            note_q  <= 4'd0;
            cnt     <= '0;
            speaker <= 1'b0;
            playing <= 1'b0;
        end else begin
            state   <= state_nxt;
            note_q  <= note;
            cnt     <= cnt_nxt;
            speaker <= speaker_nxt;
            playing <= playing_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        speaker_nxt = speaker;

        case (state)
            IDLE: begin
                speaker_nxt = 1'b0;
                if (!silent) begin
                    state_nxt   = TONE;
                    cnt_nxt     = reload;
                    speaker_nxt = 1'b1;
                end
            end
            TONE: begin
                if (speaker) begin
                    // A high phase always runs to completion, even if silence
                    // is requested part-way through it.
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end else begin
                        speaker_nxt = 1'b0;
                        if (silent) begin
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = reload;
                        end
                    end
                end else begin
                    // The pin is already low, so a low phase can be abandoned at once.
                    if (silent) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end else begin
                        speaker_nxt = 1'b1;
                        cnt_nxt     = reload;
                    end
                end
            end
        endcase

        playing_nxt = (state_nxt == TONE);
    end

endmodule

// File: tb/tb_tone_generator.sv
// Testbench for tone_generator with SIM_SHIFT = 10. It holds a queue of expected
// speaker phases as {name, level, length}. Each phase is measured on the falling
// clock edge and compared against the entry popped from that queue.

module tb_tone_generator;

    logic       CLK;
    logic       RESET;
    logic [3:0] note;
    logic       mute;
    logic       speaker;
    logic       playing;

    int n_pass;
    int n_checks;

    localparam int LIMIT = 4000;

    typedef struct {
        string name;
        logic  lvl;
        int    len;
    } phase_t;

    typedef struct {
        logic [3:0] code;
        logic       mute;
        int         hp;     // 0 means the row must stay silent
    } vec_t;

    phase_t exp_q[$];
    vec_t   vecs[14];

    tone_generator #(
        .CNT_W    (18),
        .SIM_SHIFT(10)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .note   (note),
        .mute   (mute),
        .speaker(speaker),
        .playing(playing)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input string name, input logic lvl, input int len);
        phase_t p;
        p.name = name;
        p.lvl  = lvl;
        p.len  = len;
        exp_q.push_back(p);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        mute  = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Called while the DUT is idle: drive the code, then check the one-edge
    // note_q latency followed by the rise. Afterwards the current sample is the
    // first sample of the high phase.
    task automatic start_tone(input string name, input logic [3:0] code);
        note = code;
        tick();
        check({name, " spk after note_q edge"}, int'(speaker), 0);
        tick();
        check({name, " spk start"}, int'(speaker), 1);
        check({name, " playing start"}, int'(playing), 1);
    endtask

    // Measures one phase that starts at the current sample and ends at the first
    // sample with the other level. When the sample index reaches sw_at, note is
    // changed to sw_note.
    task automatic run_phase(input int sw_at, input int sw_note);
        phase_t e;
        int n;
        if (exp_q.size() == 0) begin
            check("scoreboard underflow", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        n = 0;
        check({e.name, " level"}, int'(speaker), int'(e.lvl));
        while (speaker == e.lvl && n < LIMIT) begin
            n++;
            if (n == sw_at) note = sw_note[3:0];
            tick();
        end
        check({e.name, " length"}, n, e.len);
    endtask

    task automatic quiet(input string name, input int cycles);
        int hi;
        hi = 0;
        repeat (cycles) begin
            tick();
            if (speaker || playing) hi++;
        end
        check({name, " active samples"}, hi, 0);
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        RESET    = 1'b1;
        note     = 4'd5;
        mute     = 1'b0;

        vecs[0]  = '{4'd0,  1'b0, 0};
        vecs[1]  = '{4'd1,  1'b0, 186};
        vecs[2]  = '{4'd2,  1'b0, 166};
        vecs[3]  = '{4'd3,  1'b0, 148};
        vecs[4]  = '{4'd4,  1'b0, 139};
        vecs[5]  = '{4'd5,  1'b0, 124};
        vecs[6]  = '{4'd6,  1'b0, 110};
        vecs[7]  = '{4'd7,  1'b0, 98};
        vecs[8]  = '{4'd8,  1'b0, 93};
        vecs[9]  = '{4'd9,  1'b0, 0};
        vecs[10] = '{4'd12, 1'b0, 0};
        vecs[11] = '{4'd15, 1'b0, 0};
        vecs[12] = '{4'd5,  1'b1, 0};
        vecs[13] = '{4'd8,  1'b1, 0};

        // Reset must win even with a valid note already on the input.
        tick();
        check("reset speaker", int'(speaker), 0);
        check("reset playing", int'(playing), 0);
        tick();
        check("reset held speaker", int'(speaker), 0);
        RESET = 1'b0;
        note  = 4'd0;

        // Steady tone or silence for every code.
        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("code%0d_m%0d", vecs[i].code, vecs[i].mute);
            note = 4'd0;
            do_reset();
            if (vecs[i].hp == 0) begin
                mute = vecs[i].mute;
                note = vecs[i].code;
                quiet(nm, 300);
                mute = 1'b0;
            end else begin
                start_tone(nm, vecs[i].code);
                push({nm, " hi1"}, 1'b1, vecs[i].hp);
                push({nm, " lo1"}, 1'b0, vecs[i].hp);
                push({nm, " hi2"}, 1'b1, vecs[i].hp);
                repeat (3) run_phase(-1, 0);
                check({nm, " playing after"}, int'(playing), 1);
            end
        end

        // G -> A switch mid-high: the high phase finishes at the old pitch.
        note = 4'd0;
        do_reset();
        start_tone("g2a", 4'd5);
        push("g2a hi", 1'b1, 124);
        push("g2a lo", 1'b0, 110);
        push("g2a hi2", 1'b1, 110);
        push("g2a lo2", 1'b0, 110);
        run_phase(50, 6);
        repeat (3) run_phase(-1, 0);

        // The code changes on the reload edge itself, so the reload uses the old note_q.
        note = 4'd0;
        do_reset();
        start_tone("g2a_edge", 4'd5);
        push("g2a_edge hi", 1'b1, 124);
        push("g2a_edge lo", 1'b0, 124);
        push("g2a_edge hi2", 1'b1, 110);
        run_phase(124, 6);
        run_phase(-1, 0);
        run_phase(-1, 0);

        // The code changes one cycle before the reload edge, so the new pitch applies.
        note = 4'd0;
        do_reset();
        start_tone("g2a_pre", 4'd5);
        push("g2a_pre hi", 1'b1, 124);
        push("g2a_pre lo", 1'b0, 110);
        run_phase(123, 6);
        run_phase(-1, 0);

        // E silenced during a high phase.
        note = 4'd0;
        do_reset();
        start_tone("e_off_hi", 4'd3);
        push("e_off_hi hi", 1'b1, 148);
        run_phase(60, 0);
        check("e_off_hi playing at fall", int'(playing), 0);
        quiet("e_off_hi after", 300);

        // E silenced during a low phase: playing drops two edges later.
        note = 4'd0;
        do_reset();
        start_tone("e_off_lo", 4'd3);
        push("e_off_lo hi", 1'b1, 148);
        run_phase(-1, 0);
        repeat (39) tick();
        check("e_off_lo playing before", int'(playing), 1);
        note = 4'd0;
        tick();
        check("e_off_lo playing +1", int'(playing), 1);
        tick();
        check("e_off_lo playing +2", int'(playing), 0);
        check("e_off_lo speaker +2", int'(speaker), 0);
        quiet("e_off_lo after", 300);

        // Code 12 from reset stays silent, then C4 plays.
        note = 4'd0;
        do_reset();
        note = 4'd12;
        quiet("code12 long", 1000);
        start_tone("c4_after12", 4'd1);
        push("c4_after12 hi", 1'b1, 186);
        push("c4_after12 lo", 1'b0, 186);
        push("c4_after12 hi2", 1'b1, 186);
        repeat (3) run_phase(-1, 0);

        // One-cycle mute during a low phase of D.
        note = 4'd0;
        do_reset();
        start_tone("d_mute", 4'd2);
        push("d_mute hi", 1'b1, 166);
        run_phase(-1, 0);
        repeat (49) tick();
        mute = 1'b1;
        tick();
        mute = 1'b0;
        check("d_mute idle speaker", int'(speaker), 0);
        check("d_mute idle playing", int'(playing), 0);
        tick();
        check("d_mute restart speaker", int'(speaker), 1);
        check("d_mute restart playing", int'(playing), 1);
        push("d_mute hi2", 1'b1, 166);
        push("d_mute lo2", 1'b0, 166);
        run_phase(-1, 0);
        run_phase(-1, 0);

        // Reset in the middle of a C5 high phase.
        note = 4'd0;
        do_reset();
        start_tone("c5_rst", 4'd8);
        repeat (40) tick();
        check("c5_rst high before", int'(speaker), 1);
        RESET = 1'b1;
        tick();
        check("c5_rst speaker", int'(speaker), 0);
        check("c5_rst playing", int'(playing), 0);
        RESET = 1'b0;
        tick();
        check("c5_rst note_q edge speaker", int'(speaker), 0);
        tick();
        check("c5_rst restart speaker", int'(speaker), 1);
        check("c5_rst restart playing", int'(playing), 1);
        push("c5_rst hi", 1'b1, 93);
        push("c5_rst lo", 1'b0, 93);
        run_phase(-1, 0);
        run_phase(-1, 0);

        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
